// File: rtl/mem_a_to_b_transfer_if.sv
// rtl/mem_a_to_b_transfer_if.sv - control and memory-pin bundle for the A-to-B transfer controller
// master is the controller side; slave is the side holding the memories and the requester.
interface mem_a_to_b_transfer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [ADDR_W-1:0] addr_a;
  logic              we_a;
  logic [DATA_W-1:0] data_a;
  logic [ADDR_W-1:0] addr_b;
  logic              we_b;
  logic [DATA_W-1:0] data_b;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  modport master (
    input  start, data_a,
    output addr_a, we_a, addr_b, we_b, data_b, busy, done, wr_count
  );

  modport slave (
    output start, data_a,
    input  addr_a, we_a, addr_b, we_b, data_b, busy, done, wr_count
  );
endinterface

// File: rtl/mem_a_to_b_transfer.sv
// rtl/mem_a_to_b_transfer.sv - copies every word of memory A into memory B on a start pulse
// Two cycles per word: READ captures A's combinational data, WRITE presents it to B.
module mem_a_to_b_transfer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int DEPTH     = 8,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_a_to_b_transfer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              write_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      data_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    write_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_READ;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
      end
      S_READ: begin
        data_d  = bus.data_a;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        write_en = !(SKIP_ZERO && (data_q == '0));
        if (write_en) begin
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          wr_count_d = wr_count_q + CNT_ONE;
        end
        // Stop on the compare so a full-depth memory never relies on pointer wrap.
        if (rd_ptr_q == LAST_PTR) begin
          state_d = S_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.we_a     = 1'b0;
  assign bus.addr_a   = (state_q == S_IDLE)  ? '0 : rd_ptr_q;
  assign bus.addr_b   = (state_q == S_WRITE) ? wr_ptr_q : '0;
  assign bus.data_b   = (state_q == S_WRITE) ? data_q : '0;
  assign bus.we_b     = write_en;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.wr_count = wr_count_q;

endmodule

// File: doc/mem_a_to_b_transfer.md
Name: mem_a_to_b_transfer

Overview:
- Transfer controller for the memory-to-memory path.
- On a start pulse, it reads every location of memory A in ascending order and writes each word into memory B.
- It drives memory A's address and write-enable pins and consumes memory A's combinational read data.
- It drives memory B's address, write-enable and write-data pins, which are captured on the rising edge of clk.
- It sits between the two memory instances and replaces bench-driven sequencing once the transfer is automated.

Parameters:
- DATA_W, 8, width of one memory word.
- ADDR_W, 3, address width of both memories.
- DEPTH, 8, number of words transferred; must be at most 2**ADDR_W.
- SKIP_ZERO, 0, when 1, words equal to zero are read but not written, and B is packed densely.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- addr_a  output  ADDR_W  memory A read address.
- we_a  output  1  memory A write enable; constant 0, so the block never writes A.
- data_a  input  DATA_W  memory A read data; combinational from addr_a.
- addr_b  output  ADDR_W  memory B write address.
- we_b  output  1  memory B write enable.
- data_b  output  DATA_W  memory B write data.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse when the transfer completes.
- wr_count  output  ADDR_W+1  number of words written into B during the last or current transfer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rd_ptr=0, wr_ptr=0, data_reg=0.
  - Outputs: addr_a=0, addr_b=0, data_b=0, we_b=0, busy=0, done=0, wr_count=0.
  - Reset during a transfer aborts it immediately; any partially written B contents are left as is.
- States: IDLE, READ, WRITE, DONE. Encoding is free; all outputs come from registers or state decode only, never from start or data_a.
- IDLE:
  - start=1 → READ with rd_ptr=0, wr_ptr=0, wr_count=0.
  - start=0 → stay in IDLE.
- READ:
  - addr_a=rd_ptr.
  - data_a is captured into data_reg on the closing edge.
  - Next state is WRITE.
- WRITE:
  - addr_b=wr_ptr, data_b=data_reg.
  - we_b=1, unless SKIP_ZERO=1 and data_reg==0.
  - On a write: wr_ptr and wr_count increment.
  - If rd_ptr==DEPTH-1 → DONE; otherwise rd_ptr increments → READ.
- DONE:
  - done=1 for exactly one cycle, then → IDLE.
- Output rules:
  - we_b is high only in WRITE cycles.
  - addr_a holds rd_ptr in every non-IDLE state.
  - busy=1 in READ, WRITE and DONE.
- Timing:
  - 2 cycles per word.
  - done is asserted in the cycle 2*DEPTH+1 after the start-accept edge.
  - The last B write lands on the edge that enters DONE.
- Pointer wrap:
  - rd_ptr never exceeds DEPTH-1.
  - With DEPTH=2**ADDR_W, termination comes from the compare, not from wrap; the pointer does not wrap mid-transfer.
- Start while busy or in DONE: ignored, no queuing.
- Start held high: a new transfer begins on the first IDLE cycle after DONE.
- data_a changing outside READ has no effect.
- wr_count holds its final value after DONE until the next accepted start or reset.

Test Plan:
- Preload A = 0x23,0x87,0xB7,0xD7,0x11,0xC1,0x85,0x07, pulse start → 8 we_b pulses at addr_b 0..7 with the same data, done one cycle at cycle 17 after accept, wr_count=8, read back B matches A.
- SKIP_ZERO=1, A = 0x23,0x00,0xB7,0x00,0x00,0xC1,0x85,0x00 → B[0..3] = 0x23,0xB7,0xC1,0x85, exactly 4 we_b pulses, wr_count=4, done still at cycle 17.
- Pulse start again at cycle 6 of an active transfer → no restart, addr_a sequence unchanged, single done.
- Drop rst_n for one cycle after the third B write → all outputs 0 immediately, state IDLE, B[0..2] written and B[3..7] untouched; a new start completes a full transfer.
- Hold start=1 continuously → back-to-back transfers with exactly one IDLE cycle between done and the next READ.
- After reset with no start for 20 cycles → we_a=0 and we_b=0 throughout, busy=0, done=0.
